if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
Parametrised instruction-fetch stage that replaces the single-register PC fetch. It holds the fetch PC, issues in-order requests to instruction memory with a ready/valid handshake, and buffers returned instructions with their PCs in a DEPTH-entry queue. Decode consumes entries from the queue head. The stage supports stall, bubble injection and redirect (branch/jump) with flush and discard of in-flight responses.

Parameters:
XLEN, 32, width of PC, instruction and address paths.
DEPTH, 4, queue entries; power of two, 2..16.
PC_RESET, 32'h00000000, fetch PC after reset (XLEN bits).
INC, 4, PC increment per instruction.
NOP, 32'h00000013, instruction driven during a bubble or when empty.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
pc_src  in  1  redirect request; fetch restarts at new_pc.
new_pc  in  XLEN  redirect target.
stall_if  in  1  decode not accepting; head is held.
bubble_if  in  1  suppress output this cycle; no pop.
imem_req  out  1  request valid.
imem_addr  out  XLEN  request address.
imem_ready  in  1  memory accepts request this cycle.
imem_rvalid  in  1  response valid; responses return in request order, latency >= 1.
imem_rdata  in  XLEN  response instruction.
out_valid  out  1  instr/pc valid to decode.
instr  out  XLEN  head instruction, or NOP.
pc  out  XLEN  head PC.
pc_plus4  out  XLEN  pc + INC.

Behaviour:
- Reset (async, while rst=1): fetch_pc=PC_RESET, resp_pc=PC_RESET, count=0, inflight=0, discard=0, pointers=0, imem_req=0, out_valid=0, instr=NOP, pc=PC_RESET, pc_plus4=PC_RESET+INC. Imem shares rst; no pre-reset response arrives after reset.
- Credit rule: imem_req = !pc_src && (count + inflight < DEPTH). imem_addr = fetch_pc.
- Request fires when imem_req && imem_ready: fetch_pc += INC (mod 2^XLEN wrap), inflight++.
- Response, discard>0: data dropped, discard--, inflight--.
- Response, discard==0: push {resp_pc, imem_rdata} at tail, resp_pc += INC, inflight--.
- Output is combinational from the head: out_valid = (count>0) && !bubble_if && !pc_src.
  - When out_valid=0, instr=NOP; pc and pc_plus4 still show the head.
- Pop when out_valid && !stall_if.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Credit rule guarantees no push when full. A push when count==DEPTH is an assertion failure.
- Redirect (pc_src=1), evaluated at the clock edge, takes priority over everything:
  - queue cleared (count=0, pointers=0); fetch_pc=new_pc; resp_pc=new_pc.
  - no request issued this cycle; a same-cycle response is dropped.
  - discard = inflight − (imem_rvalid?1:0); inflight is updated the same way.
  - requests from new_pc start the next cycle.
- Back-to-back redirects: the last one wins; discard accumulates correctly from the current inflight.
- Stall: no pop; fetching continues until count+inflight==DEPTH, then imem_req=0.
- Bubble: out_valid=0 and instr=NOP for that cycle only; the head is retained.
- Pointers wrap modulo DEPTH. count and inflight are ceil(log2(DEPTH+1)) bits wide.

Test Plan:
- Reset then 1-cycle imem, no stall -> requests 0x0,0x4,0x8,...; out_valid first at cycle 2, pc=0x0, pc_plus4=0x4; one instruction per cycle thereafter.
- stall_if held 10 cycles, DEPTH=4 -> imem_req drops after count+inflight=4; head pc stays constant; no data lost on release; pc sequence contiguous.
- Redirect with 2 requests in flight (latency 3), new_pc=0x100 -> both stale responses dropped; next out_valid shows pc=0x100, instr from 0x100; queue empty during flush.
- pc_src and imem_rvalid in the same cycle -> that response dropped; discard=inflight−1; first delivered pc equals new_pc.
- bubble_if pulse with head pc=0x20 -> that cycle out_valid=0, instr=0x00000013; next cycle pc=0x20 delivered.
- 40 instructions with random imem_ready and latency 1–4, random stall -> pointer wrap exercised; delivered pcs strictly +4 with no duplicates; fetch_pc wrap from 0xFFFFFFFC to 0x0; async rst mid-run returns pc=PC_RESET immediately.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry instruction queue.
//
// Holds the fetch PC, issues in-order requests to instruction memory
// (ready/valid), and buffers returned instructions with their PCs. Decode
// consumes entries from the queue head. A redirect (pc_src) clears the
// queue, restarts fetch at new_pc, and marks every outstanding request as
// stale so that its response is dropped when it arrives.
//
// Ports:
//   clk, rst     - clock (rising edge), asynchronous active-high reset
//   pc_src       - redirect request; fetch restarts at new_pc
//   new_pc       - redirect target
//   stall_if     - decode not accepting; head is held
//   bubble_if    - suppress output this cycle without popping
//   imem_req     - request valid; imem_addr carries the fetch PC
//   imem_ready   - memory accepts the request this cycle
//   imem_rvalid  - response valid (in request order, latency >= 1)
//   imem_rdata   - response instruction
//   out_valid    - instr/pc valid to decode
//   instr        - head instruction, or NOP when out_valid is low
//   pc, pc_plus4 - head PC and head PC + INC

module if_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter int unsigned     INC      = 4,
  parameter logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_src,
  input  logic [XLEN-1:0] new_pc,
  input  logic            stall_if,
  input  logic            bubble_if,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  localparam int unsigned     CW      = $clog2(DEPTH + 1);
  localparam int unsigned     PW      = $clog2(DEPTH);
  localparam logic [XLEN-1:0] INC_W   = XLEN'(INC);
  localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]   FULL    = CW'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [CW:0]     occupancy;
  logic            fire;
  logic            push;
  logic            pop;
  logic            not_empty;
  logic [XLEN-1:0] head_pc;

  // Credit covers both buffered entries and requests still in flight, so a
  // response always finds a free slot.
  assign occupancy = {1'b0, count} + {1'b0, inflight};
  assign imem_req  = !rst && !pc_src && (occupancy < DEPTH_W);
  assign imem_addr = fetch_pc;
  assign fire      = imem_req && imem_ready;

  // A response is kept only when it is not stale and no redirect is taking
  // effect at the same edge.
  assign push      = imem_rvalid && !pc_src && (discard == '0);

  assign not_empty = (count != '0);
  assign out_valid = not_empty && !bubble_if && !pc_src;
  assign pop       = out_valid && !stall_if;

  // With an empty queue the head position shows the PC of the next entry
  // to arrive, which is PC_RESET after reset and new_pc after a redirect.
  assign head_pc   = not_empty ? pc_mem[rd_ptr] : resp_pc;
  assign pc        = head_pc;
  assign pc_plus4  = head_pc + INC_W;
  assign instr     = out_valid ? instr_mem[rd_ptr] : NOP;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= PC_RESET;
      resp_pc  <= PC_RESET;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (pc_src) begin
      // Every outstanding request belongs to the old path; the one
      // returning at this edge is dropped here, the rest are discarded
      // as they arrive.
      fetch_pc <= new_pc;
      resp_pc  <= new_pc;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= inflight - CW'(imem_rvalid);
      discard  <= inflight - CW'(imem_rvalid);
    end else begin
      if (fire) fetch_pc <= fetch_pc + INC_W;
      inflight <= inflight + CW'(fire) - CW'(imem_rvalid);
      if (imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
      if (push) begin
        resp_pc <= resp_pc + INC_W;
        wr_ptr  <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: the entry storage has no reset; count gates every read, so stale
  // contents are never observed and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= resp_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

`ifndef SYNTHESIS
  no_push_when_full: assert property (
    @(posedge clk) disable iff (rst) push |-> (count != FULL)
  );
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Testbench for if_fetch_queue: randomized stimulus, a bench-side
// instruction memory, and a scoreboard of expected {pc, instr} deliveries.
// Outstanding requests are tagged with a redirect epoch; a response is
// expected at decode only if its epoch is still current.

module tb_if_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_src = 1'b0;
  logic [31:0] new_pc = '0;
  logic        stall_if = 1'b0;
  logic        bubble_if = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  if_fetch_queue #(
    .XLEN(32), .DEPTH(DEPTH), .PC_RESET(PC_RESET), .INC(4), .NOP(NOP)
  ) dut (
    .clk(clk), .rst(rst), .pc_src(pc_src), .new_pc(new_pc),
    .stall_if(stall_if), .bubble_if(bubble_if),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned ep;
    int unsigned due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  req_t pend[$];     // requests accepted by memory, oldest first
  ent_t sb[$];       // entries decode should see, oldest first

  logic [31:0] m_fetch = PC_RESET;
  int unsigned epoch = 0;
  int unsigned cyc = 0;

  int vectors = 0;
  int miscompares = 0;

  // stimulus knobs (percentages and latency range)
  int unsigned p_stall = 0, p_bubble = 0, p_redirect = 0, p_ready = 100;
  int unsigned lat_min = 1, lat_max = 1;
  logic        force_redir = 1'b0;
  logic        redir_on_resp = 1'b0;
  logic [31:0] force_target = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F11;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares decode-side outputs against the scoreboard head.
  initial begin
    ent_t e;
    logic exp_v;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        exp_v = (sb.size() > 0) && !bubble_if && !pc_src;
        check("out_valid", 32'(out_valid), 32'(exp_v));
        if (out_valid && exp_v) begin
          e = sb[0];
          check("pc", pc, e.pc);
          check("instr", instr, e.ins);
          check("pc_plus4", pc_plus4, e.pc + 32'd4);
          if (!stall_if) void'(sb.pop_front());
        end else if (!out_valid) begin
          check("instr_nop", instr, NOP);
        end
      end
    end
  end

  // One clock cycle of stimulus plus memory and reference-model update.
  task automatic step();
    logic   resp, m_req, fire, keep;
    req_t   r;
    int unsigned lat;
    @(negedge clk);
    resp        = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rvalid = resp;
    imem_rdata  = resp ? mem_word(pend[0].addr) : $urandom;
    stall_if    = ($urandom_range(99) < p_stall);
    bubble_if   = ($urandom_range(99) < p_bubble);
    imem_ready  = ($urandom_range(99) < p_ready);
    if (force_redir) begin
      pc_src = 1'b1; new_pc = force_target; force_redir = 1'b0;
    end else if (redir_on_resp && resp) begin
      pc_src = 1'b1; new_pc = force_target; redir_on_resp = 1'b0;
    end else begin
      pc_src = ($urandom_range(99) < p_redirect);
      new_pc = $urandom & 32'h0000_FFFC;
    end
    #2;
    m_req = !pc_src && (sb.size() + pend.size() < DEPTH);
    check("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) check("imem_addr", imem_addr, m_fetch);
    fire = m_req && imem_ready;
    @(posedge clk);
    keep = 1'b0;
    if (resp) begin
      r = pend.pop_front();
      keep = !pc_src && (r.ep == epoch);
    end
    if (pc_src) begin
      sb.delete();
      epoch++;
      m_fetch = new_pc;
    end else begin
      if (keep) sb.push_back(ent_t'{pc: r.addr, ins: mem_word(r.addr)});
      if (fire) begin
        lat = $urandom_range(lat_max, lat_min);
        pend.push_back(req_t'{addr: m_fetch, ep: epoch, due: cyc + lat});
        m_fetch = m_fetch + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asserts reset between clock edges and checks outputs react at once.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    pc_src = 1'b0; stall_if = 1'b0; bubble_if = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0;
    sb.delete();
    pend.delete();
    m_fetch = PC_RESET;
    epoch++;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pc, PC_RESET);
    check("rst_pc_plus4", pc_plus4, PC_RESET + 32'd4);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // 1-cycle memory, no stall: one instruction per cycle from PC_RESET
    run(20);

    // decode stalled for 10 cycles, then released
    p_stall = 100;
    run(10);
    p_stall = 0;
    run(10);

    // redirect to 0x100 with latency-3 requests in flight
    lat_min = 3; lat_max = 3;
    run(6);
    force_target = 32'h0000_0100;
    force_redir = 1'b1;
    run(15);

    // redirect in the same cycle as a response
    lat_min = 2; lat_max = 2;
    force_target = 32'h0000_0200;
    redir_on_resp = 1'b1;
    for (int i = 0; i < 20 && redir_on_resp; i++) step();
    check("same_cycle_redirect_taken", 32'(redir_on_resp), 32'd0);
    run(10);

    // bubbles
    lat_min = 1; lat_max = 1;
    p_bubble = 30;
    run(20);

    // fully random traffic
    p_stall = 30; p_bubble = 15; p_redirect = 4; p_ready = 70;
    lat_min = 1; lat_max = 4;
    run(80);

    // fetch PC wrap across the top of the address space
    p_redirect = 0;
    force_target = 32'hFFFF_FFF4;
    force_redir = 1'b1;
    run(40);

    // asynchronous reset mid-run, then random traffic again
    do_reset();
    p_redirect = 4;
    run(60);

    // drain with everything quiet
    p_stall = 0; p_bubble = 0; p_redirect = 0; p_ready = 100;
    run(15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
